// File: rtl/mem16x8_pkg.sv
// Shared definitions for the 16x8 data memory: default geometry and the power-on image.
// CPU-side reference models reuse init_word to predict memory contents after reset.
package mem16x8_pkg;

   localparam int AW = 4;
   localparam int DW = 8;

   // Power-on image word: upper nibble is the inverted address, lower nibble the address.
   function automatic logic [7:0] init_word(input logic [3:0] i);
      return {~i, i};
   endfunction

endpackage

// File: rtl/mem16x8.sv
// 16-word x 8-bit data memory: synchronous write, reset reloads a fixed image.
// Read is combinational unless MEM_REG_OUT_EN is defined (registered, write-first, 1-cycle latency).
module mem16x8
   import mem16x8_pkg::*;
#(
   parameter int AW = mem16x8_pkg::AW,
   parameter int DW = mem16x8_pkg::DW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] addr,
   input  logic          we,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] data
);

   localparam int DEPTH = 2 ** AW;

   logic [DW-1:0] mem_reg [DEPTH];
   logic [DW-1:0] image   [DEPTH];

   // The nibble pattern only fits the 16x8 geometry; other widths fall back to the index itself.
   function automatic logic [DW-1:0] image_word(input int i);
      if (DW == 8 && AW == 4) begin
         return DW'(init_word(4'(i)));
      end
      return DW'(i);
   endfunction

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_image
         assign image[gi] = image_word(gi);
      end
   endgenerate

   // Reset has priority, so a write issued in the reset cycle is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_reg[i] <= image[i];
         end
      end else if (we) begin
         mem_reg[addr] <= din;
      end
   end

`ifdef MEM_REG_OUT_EN
   logic [DW-1:0] data_reg;

   // Write-first: a write in the same cycle forwards din rather than the old word.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_reg <= '0;
      end else if (we) begin
         data_reg <= din;
      end else begin
         data_reg <= mem_reg[addr];
      end
   end

   assign data = data_reg;
`else
   assign data = mem_reg[addr];
`endif

endmodule

// File: tb/tb_mem16x8.sv
// Scoreboard bench for mem16x8: stimulus queues expected read data, a negedge monitor compares.
// Covers the combinational default build and, with MEM_REG_OUT_EN, the registered read.
module tb_mem16x8;

   logic       clk;
   logic       rst;
   logic [3:0] addr;
   logic       we;
   logic [7:0] din;
   logic [7:0] data;

   mem16x8 dut (
      .clk  (clk),
      .rst  (rst),
      .addr (addr),
      .we   (we),
      .din  (din),
      .data (data)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   // Hand-written power-on image, {~i, i}.
   logic [7:0] img [16] = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5, 8'h96, 8'h87,
                            8'h78, 8'h69, 8'h5A, 8'h4B, 8'h3C, 8'h2D, 8'h1E, 8'h0F};

   logic [7:0] exp_q  [$];
   string      name_q [$];
   int         checks   = 0;
   int         failures = 0;
   logic       done     = 1'b0;

   task automatic expect_data(input logic [7:0] exp, input string name);
      exp_q.push_back(exp);
      name_q.push_back(name);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present addr, check the zero-latency read this cycle.
   task automatic rd(input logic [3:0] a, input logic [7:0] exp, input string name);
      addr = a;
      expect_data(exp, name);
      tick();
   endtask

   // Write for one edge; during the cycle the old word must still be visible.
   task automatic wr(input logic [3:0] a, input logic [7:0] d, input logic [7:0] old, input string name);
      addr = a;
      din  = d;
      we   = 1'b1;
      expect_data(old, name);
      tick();
      we   = 1'b0;
   endtask

   // Monitor: one comparison per queued transaction, sampled at the falling edge.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         automatic logic [7:0] e = exp_q.pop_front();
         automatic string      n = name_q.pop_front();
         checks++;
         if (data !== e) begin
            failures++;
            $display("FAIL %s addr=%h data=%h expected=%h", n, addr, data, e);
         end else begin
            $display("ok   %s addr=%h data=%h", n, addr, data);
         end
      end else if (done) begin
         $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
         $finish;
      end
      if ($time > 100000) begin
         checks++;
         failures++;
         $display("FAIL timeout pending=%0d expected=0", exp_q.size());
         $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
         $finish;
      end
   end

   initial begin
      rst  = 1'b1;
      we   = 1'b0;
      addr = 4'h0;
      din  = 8'h00;
`ifdef MEM_REG_OUT_EN
      tick();
      expect_data(8'h00, "reg_reset_zero");
      rst  = 1'b0;
      addr = 4'hE;
      tick();
      expect_data(8'h1E, "reg_latency_e");
      tick();
      wr(4'hE, 8'h99, 8'h1E, "reg_before_write");
      expect_data(8'h99, "reg_write_first");
      tick();
      expect_data(8'h99, "reg_reread_e");
      addr = 4'hC;
      tick();
      expect_data(8'h3C, "reg_read_c");
      addr = 4'h0;
      tick();
      expect_data(8'hF0, "reg_read_0");
      addr = 4'hF;
      tick();
      expect_data(8'h0F, "reg_read_f");
      rst = 1'b1;
      tick();
      expect_data(8'h00, "reg_reset_again");
      rst = 1'b0;
      tick();
`else
      tick();
      rst = 1'b0;
      // Test 1: image readback, zero latency
      rd(4'h0, 8'hF0, "img_0");
      rd(4'hC, 8'h3C, "img_c");
      rd(4'hD, 8'h2D, "img_d");
      rd(4'hE, 8'h1E, "img_e");
      rd(4'hF, 8'h0F, "img_f");
      // Test 2: single write
      wr(4'hC, 8'hA5, 8'h3C, "rdw_old_c");
      rd(4'hC, 8'hA5, "wr_c");
      rd(4'hD, 8'h2D, "keep_d");
      rd(4'h0, 8'hF0, "keep_0");
      // Test 3: reset restores the whole image
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 16; i++) rd(4'(i), img[i], "reset_img");
      // Test 4: reset beats a simultaneous write
      addr = 4'h5;
      din  = 8'h77;
      we   = 1'b1;
      rst  = 1'b1;
      tick();
      we   = 1'b0;
      rst  = 1'b0;
      rd(4'h5, 8'hA5, "rst_over_we");
      // Test 5: fill with i^55, read back
      for (int i = 0; i < 16; i++) wr(4'(i), 8'(i) ^ 8'h55, img[i], "fill_old");
      for (int i = 0; i < 16; i++) rd(4'(i), 8'(i) ^ 8'h55, "fill_read");
`endif
      tick();
      done = 1'b1;
   end

endmodule
